multi_countdown: RTL

- NUM_CH independent BCD countdown timers. This is the parametrised successor to the single countdown timer in the wristwatch top level.
- Each channel counts MM:SS (or HH:MM:SS) down on a shared 1 Hz tick enable, then rings a buzzer for a bounded duration.
- Commands target one channel through ch_sel. The selected channel's digits drive the BCD display mux.
- buzz feeds the shared externalBuzz OR.

---
 rtl/multi_countdown.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/multi_countdown.sv
// rtl/multi_countdown.sv - NUM_CH independent BCD countdown timers with bounded ring and shared buzzer
//
// Optional feature macro: AUTO_RELOAD_EN
//   undefined : expiry moves the channel to RING for RING_TICKS ticks, then IDLE
//   defined   : expiry reloads the last loaded value and keeps counting, while a
//               separate ring counter drives ringing for RING_TICKS ticks
//
// Ports:
//   uclock       system clock
//   rst_n        asynchronous active-low reset
//   tick         one-cycle 1 Hz enable, synchronous to uclock
//   ch_sel       channel addressed by commands and by the display read
//   load         load load_val into the selected channel (IDLE/PAUSE only)
//   load_val     BCD value, digit 0 = seconds units
//   start        start/resume the selected channel
//   stop         pause the selected channel
//   clear        selected channel to IDLE with value 0
//   ack          silence the selected channel's ring
//   disp_digits  value of channel ch_sel, 0 when ch_sel is out of range
//   running      per-channel RUN state
//   ringing      per-channel ring active
//   buzz         OR of ringing, registered
//   err          one-cycle pulse on a rejected command
//   Command priority within one cycle: clear > load > stop > start > ack.

module multi_countdown #(
  parameter int NUM_CH     = 4,
  parameter int SEL_W      = 2,
  parameter int DIGITS     = 4,
  parameter int RING_TICKS = 30
) (
  input  logic                  uclock,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic [SEL_W-1:0]      ch_sel,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  ack,
  output logic [4*DIGITS-1:0]   disp_digits,
  output logic [NUM_CH-1:0]     running,
  output logic [NUM_CH-1:0]     ringing,
  output logic                  buzz,
  output logic                  err
);

  localparam int               VAL_W      = 4 * DIGITS;
  localparam logic [SEL_W:0]   NUM_CH_EXT = (SEL_W + 1)'(NUM_CH);
  localparam logic [7:0]       RING_INIT  = 8'(RING_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_RING
  } state_t;

  // Odd digits below the top one are tens of seconds/minutes (0..5);
  // every other digit, including the most significant, runs 0..9.
  function automatic logic [3:0] digit_lim(input int i);
    return ((i % 2 == 1) && (i < DIGITS - 1)) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic bcd_ok(input logic [VAL_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > digit_lim(i)) ok = 1'b0;
    end
    return ok;
  endfunction

  // Subtract one with a BCD borrow chain: a zero digit wraps to its limit
  // and passes the borrow upward, e.g. 10:00 -> 09:59.
  function automatic logic [VAL_W-1:0] bcd_dec(input logic [VAL_W-1:0] v);
    logic [VAL_W-1:0] r;
    logic             borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = digit_lim(i);
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic             sel_ok;
  logic             cmd_any;
  logic [NUM_CH-1:0] rej;
  logic [VAL_W-1:0] val_arr [NUM_CH];

  assign sel_ok  = ({1'b0, ch_sel} < NUM_CH_EXT);
  assign cmd_any = clear | load | stop | start | ack;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           state;
    logic [VAL_W-1:0] value;
    logic [VAL_W-1:0] dec_val;
    logic [7:0]       ring_cnt;
    logic             hit;
    logic             load_bad;
    logic             start_bad;

    // Any asserted command on this channel consumes the cycle, so a tick
    // arriving together with it is dropped for this channel only.
    assign hit       = sel_ok && cmd_any && (ch_sel == SEL_W'(g));
    assign dec_val   = bcd_dec(value);
    assign load_bad  = (state == ST_RUN) || (state == ST_RING) || !bcd_ok(load_val);
    assign start_bad = (state != ST_RUN) && ((value == '0) || (state == ST_RING));

    // Only the highest-priority asserted command may raise err.
    assign rej[g] = hit && !clear && (load ? load_bad : (!stop && start && start_bad));

    assign running[g] = (state == ST_RUN);
    assign val_arr[g] = value;

`ifdef AUTO_RELOAD_EN
    logic [VAL_W-1:0] reload;

    assign ringing[g] = (ring_cnt != 8'd0);

    always_ff @(posedge uclock or negedge rst_n) begin
      if (!rst_n) begin
        state    <= ST_IDLE;
        value    <= '0;
        reload   <= '0;
        ring_cnt <= 8'd0;
      end else if (hit) begin
        if (clear) begin
          state    <= ST_IDLE;
          value    <= '0;
          reload   <= '0;
          ring_cnt <= 8'd0;
        end else if (load) begin
          if (!load_bad) begin
            value  <= load_val;
            reload <= load_val;
          end
        end else if (stop) begin
          if (state == ST_RUN) state <= ST_PAUSE;
        end else if (start) begin
          if (((state == ST_IDLE) || (state == ST_PAUSE)) && (value != '0)) state <= ST_RUN;
        end else begin
          // ack silences the ring but leaves the count alone
          ring_cnt <= 8'd0;
        end
      end else if (tick) begin
        // The ring timer runs on its own, so it keeps timing out even when paused.
        if (ring_cnt != 8'd0) ring_cnt <= ring_cnt - 8'd1;
        if (state == ST_RUN) begin
          value <= dec_val;
          if (dec_val == '0) begin
            value    <= reload;
            ring_cnt <= RING_INIT;
            if (reload == '0) state <= ST_IDLE;
          end
        end
      end
    end
`else
    assign ringing[g] = (state == ST_RING);

    always_ff @(posedge uclock or negedge rst_n) begin
      if (!rst_n) begin
        state    <= ST_IDLE;
        value    <= '0;
        ring_cnt <= 8'd0;
      end else if (hit) begin
        if (clear) begin
          state    <= ST_IDLE;
          value    <= '0;
          ring_cnt <= 8'd0;
        end else if (load) begin
          if (!load_bad) value <= load_val;
        end else if (stop) begin
          if (state == ST_RUN) state <= ST_PAUSE;
        end else if (start) begin
          if (((state == ST_IDLE) || (state == ST_PAUSE)) && (value != '0)) state <= ST_RUN;
        end else begin
          if (state == ST_RING) begin
            state    <= ST_IDLE;
            ring_cnt <= 8'd0;
          end
        end
      end else if (tick) begin
        case (state)
          ST_RUN: begin
            value <= dec_val;
            if (dec_val == '0) begin
              state    <= ST_RING;
              ring_cnt <= RING_INIT;
            end
          end
          ST_RING: begin
            // The tick that brings the counter to zero ends the ring,
            // giving exactly RING_TICKS ringing ticks after expiry.
            if (ring_cnt <= 8'd1) begin
              state    <= ST_IDLE;
              ring_cnt <= 8'd0;
            end else begin
              ring_cnt <= ring_cnt - 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
`endif
  end

  always_comb begin
    disp_digits = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_ok && (ch_sel == SEL_W'(i))) disp_digits = val_arr[i];
    end
  end

  always_ff @(posedge uclock or negedge rst_n) begin
    if (!rst_n) begin
      err  <= 1'b0;
      buzz <= 1'b0;
    end else begin
      err  <= cmd_any && (!sel_ok || (|rej));
      buzz <= |ringing;
    end
  end

endmodule
